seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial sequence detector, successor to the fixed single-pattern Mealy/Moore detectors used in the lab designs.
- Watches a 1-bit serial stream qualified by a valid strobe and compares the last N accepted bits against a runtime-loadable pattern.
- Supports overlapping and non-overlapping detection modes.
- Provides a one-clock match pulse and a saturating match counter; sits between a serial bit source and any control/status logic.

Parameters:
- N, 4: pattern length in bits (legal range 2..16).
- PAT_DEFAULT, 4'b1101: pattern loaded at reset. Width N; MSB is the oldest bit.
- CNT_W, 8: match counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit-valid strobe; x is accepted only on edges where en=1.
- x  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every edge.
- pat_load  input  1  synchronous pattern load strobe.
- pat_in  input  N  new pattern; MSB is the oldest bit.
- cnt_clr  input  1  synchronous clear of the match counter.
- y  output  1  registered match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Async reset (rst=1), applied immediately regardless of clk:
  - pattern register = PAT_DEFAULT; history = 0; fill = 0.
  - y = 0; match_cnt = 0; cnt_sat = 0.
- Internal state:
  - hist[N-1:0]: shift register. On an accepted bit, hist <= {hist[N-2:0], x}.
  - fill: count of accepted bits since the last clear, saturating at N; width clog2(N+1).
- Accepted bit: en=1 and pat_load=0 at the rising edge.
- Match condition, evaluated on the accepted bit: (fill_next == N) and ({hist[N-2:0], x} == pattern).
- y timing: y is registered and high for exactly one clock after the edge that accepts the completing bit, i.e. latency 1 edge. y is 0 on every other edge, including edges with en=0.
- On a match, overlap=1: hist and fill are kept, so the trailing bits can begin the next match.
- On a match, overlap=0: fill <= 0, so the next match requires N fresh accepted bits. hist still shifts.
- en=0: hist, fill and pattern hold; y <= 0. Gaps are transparent to the sequence.
- pat_load=1:
  - pattern <= pat_in; hist <= 0; fill <= 0; y <= 0.
  - Any x offered on that edge is discarded, even if en=1.
- match_cnt:
  - Increments by 1 on each match edge; saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat is a registered output equal to (match_cnt == all-ones).
- cnt_clr=1: match_cnt <= 0 and cnt_sat <= 0. cnt_clr has priority over a same-edge increment (result 0). y still pulses normally.
- Reset mid-sequence discards all partial progress; the first N accepted bits after release cannot produce a match until fill reaches N.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, default pattern 1101, overlap=1, en=1, x = 1,1,0,1,1,0,1 on consecutive edges -> y pulses after the 4th and 7th bits; match_cnt=2.
- Same stream with overlap=0 -> y pulses only after the 4th bit; match_cnt=1. Appending x = 1,1,0,1 gives a second pulse after the 11th bit.
- pat_load with pat_in=0110, then x = 0,1,1,0,1,1,0 -> pulses after the 4th and 7th bits (overlap=1). Assert en=1 together with pat_load -> that bit is dropped and fill=0.
- x = 1,1,0 then rst pulse mid-cycle (async), then x = 1 -> no y; match_cnt=0. After a further 1,1,0,1 -> one pulse.
- Stream 1,1,0,1 with en=0 for 3 cycles inserted between each bit (x toggling randomly while en=0) -> exactly one y pulse, one clock after the edge accepting the final 1.
- CNT_W=2, five matches -> match_cnt stays 3 and cnt_sat=1. cnt_clr asserted on the same edge as a sixth match -> match_cnt=0, cnt_sat=0, y=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial sequence detector: compares the last N accepted bits against a loadable
// pattern, with overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_param #(
    parameter int             N           = 4,
    parameter logic [N-1:0]   PAT_DEFAULT = N'(4'b1101),
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int               FW        = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [N-1:0]     pat_q, pat_d;
    logic [N-1:0]     hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic             accept;
    logic             match;
    logic [N-1:0]     hist_shift;
    logic [FW-1:0]    fill_inc;

    always_comb begin
        accept     = en & ~pat_load;
        hist_shift = {hist_q[N-2:0], x};
        fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        match      = accept && (fill_inc == FILL_FULL) && (hist_shift == pat_q);

        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        y_d    = match;
        cnt_d  = cnt_q;

        if (pat_load) begin
            // A load restarts the search; the bit offered on this edge is dropped.
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = (match && !overlap) ? '0 : fill_inc;
        end

        if (cnt_clr)
            cnt_d = '0;
        else if (match && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;

        // Derived from the next count so cnt_sat tracks match_cnt on the same edge.
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_DEFAULT;
            hist_q <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are checked every edge against a queue-based reference model.
module tb_seq_detector_param;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, en, x, overlap, pat_load, cnt_clr;
    logic [N-1:0] pat_in;
    logic         y8, y2, sat8, sat2;
    logic [7:0]   cnt8;
    logic [1:0]   cnt2;

    always #5 clk = ~clk;

    seq_detector_param #(.N(N), .PAT_DEFAULT(4'b1101), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y8), .match_cnt(cnt8), .cnt_sat(sat8));

    seq_detector_param #(.N(N), .PAT_DEFAULT(4'b1101), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .y(y2), .match_cnt(cnt2), .cnt_sat(sat2));

    int compared   = 0;
    int mismatched = 0;

    // Reference model: recent accepted bits, bits since last restart, uncapped count.
    int m_q[$];
    int m_fill;
    int m_pat;
    int m_cnt;
    bit m_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_q.delete();
        m_fill = 0;
        m_pat  = 4'b1101;
        m_cnt  = 0;
        m_y    = 1'b0;
    endfunction

    function automatic int m_window();
        int w = 0;
        foreach (m_q[i]) w = (w << 1) | m_q[i];
        return w;
    endfunction

    task automatic check_all(input string tag);
        int c8, c2;
        c8 = (m_cnt > 255) ? 255 : m_cnt;
        c2 = (m_cnt > 3) ? 3 : m_cnt;
        chk({tag, ".y8"},   32'(y8),   32'(m_y));
        chk({tag, ".y2"},   32'(y2),   32'(m_y));
        chk({tag, ".cnt8"}, 32'(cnt8), 32'(c8));
        chk({tag, ".cnt2"}, 32'(cnt2), 32'(c2));
        chk({tag, ".sat8"}, 32'(sat8), 32'(c8 == 255));
        chk({tag, ".sat2"}, 32'(sat2), 32'(c2 == 3));
    endtask

    task automatic step(input string tag, input bit e, input bit b, input bit ov,
                        input bit pl, input logic [N-1:0] pin, input bit clr);
        en = e; x = b; overlap = ov; pat_load = pl; pat_in = pin; cnt_clr = clr;
        @(posedge clk);
        m_y = 1'b0;
        if (pl) begin
            m_pat = int'(pin);
            m_q.delete();
            m_fill = 0;
        end else if (e) begin
            m_q.push_back(int'(b));
            if (m_q.size() > N) void'(m_q.pop_front());
            if (m_fill < N) m_fill++;
            if (m_fill == N && m_window() == m_pat) begin
                m_y = 1'b1;
                m_cnt++;
                if (!ov) m_fill = 0;
            end
        end
        if (clr) m_cnt = 0;
        #1;
        check_all(tag);
    endtask

    task automatic bits(input string tag, input int v, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, v[i], ov, 1'b0, '0, 1'b0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic areset(input string tag);
        rst = 1'b1;
        #2;
        m_reset();
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 0; x = 0; overlap = 1; pat_load = 0; pat_in = '0; cnt_clr = 0;
        m_reset();
        #3;
        check_all("reset");
        rst = 1'b0;

        // Overlapping: 1101101 matches after bits 4 and 7.
        bits("A", 7'b1101101, 7, 1'b1);
        chk("A.total", 32'(cnt8), 32'd2);

        // Non-overlapping: only bit 4 matches, then 1101 adds one more.
        areset("B.rst");
        bits("B", 7'b1101101, 7, 1'b0);
        chk("B.total", 32'(cnt8), 32'd1);
        bits("B2", 4'b1101, 4, 1'b0);
        chk("B2.total", 32'(cnt8), 32'd2);

        // Load 0110 with en=1 and x=0: that bit must be dropped.
        step("C.load", 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110, 1'b0);
        bits("C.pre", 3'b110, 3, 1'b1);
        chk("C.pre_y", 32'(y8), 32'd0);
        bits("C", 7'b0110110, 7, 1'b1);
        chk("C.total", 32'(cnt8), 32'd4);

        // Reset mid-sequence discards progress.
        areset("D.rst0");
        bits("D.pre", 3'b110, 3, 1'b1);
        areset("D.rst1");
        bits("D.one", 1'b1, 1, 1'b1);
        chk("D.no_y", 32'(y8), 32'd0);
        bits("D", 4'b1101, 4, 1'b1);
        chk("D.total", 32'(cnt8), 32'd1);

        // Gaps with en=0 are transparent.
        areset("E.rst");
        for (int i = 3; i >= 0; i--) begin
            step("E.bit", 1'b1, 4'b1101 >> i, 1'b1, 1'b0, '0, 1'b0);
            if (i == 0) chk("E.pulse", 32'(y8), 32'd1);
            for (int g = 0; g < 3; g++)
                step("E.gap", 1'b0, 1'($urandom), 1'b1, 1'b0, '0, 1'b0);
        end
        chk("E.total", 32'(cnt8), 32'd1);

        // Saturation of the 2-bit counter, then clear on the same edge as a match.
        areset("F.rst");
        bits("F", 16'b1101101101101101, 16, 1'b1);
        chk("F.cnt2", 32'(cnt2), 32'd3);
        chk("F.sat2", 32'(sat2), 32'd1);
        chk("F.cnt8", 32'(cnt8), 32'd5);
        bits("F.tail", 2'b10, 2, 1'b1);
        step("F.clr", 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        chk("F.clr_y", 32'(y8), 32'd1);
        chk("F.clr_cnt8", 32'(cnt8), 32'd0);
        chk("F.clr_cnt2", 32'(cnt2), 32'd0);
        chk("F.clr_sat2", 32'(sat2), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("R", ($urandom_range(3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(40) == 0), 4'($urandom), ($urandom_range(60) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
